// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
// Op codes follow the EX-stage encoding; states drive the sequencer in muldiv_ctrl.
package muldiv_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned CntWidth     = 6;

  typedef enum logic [1:0] {
    OpMult  = 2'd0,
    OpMultu = 2'd1,
    OpDiv   = 2'd2,
    OpDivu  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One-bit-per-cycle datapath: unsigned shift-add multiply or restoring divide.
// Operates on magnitudes only; sign handling lives in muldiv_ctrl.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] upper_o,
  output logic [WIDTH-1:0] lower_o
);

  logic [WIDTH-1:0] upper_q, upper_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    upper_d   = upper_q;
    lower_d   = lower_q;
    operand_d = operand_q;
    sum       = {1'b0, upper_q} + (lower_q[0] ? {1'b0, operand_q} : '0);
    shifted   = {upper_q, lower_q[WIDTH-1]};
    diff      = shifted - {1'b0, operand_q};

    if (load_i) begin
      upper_d   = '0;
      lower_d   = a_i;
      operand_d = b_i;
    end else if (step_i) begin
      if (is_div_i) begin
        // Borrow out of the trial subtraction means restore the shifted remainder.
        upper_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        lower_d = {lower_q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
        upper_d = sum[WIDTH:1];
        lower_d = {sum[0], lower_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upper_q   <= '0;
      lower_q   <= '0;
      operand_q <= '0;
    end else begin
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      operand_q <= operand_d;
    end
  end

  assign upper_o = upper_q;
  assign lower_o = lower_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: IDLE/RUN/FIX sequencer, sign handling and
// the architectural HI/LO registers, with an EX-stage stall interface.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_rd,
  input  logic [1:0]       hilo_we,
  output logic             stall_EX,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(WIDTH - 1);

  muldiv_state_e       state_q, state_d;
  muldiv_op_e          op_q, op_d;
  muldiv_op_e          op_in;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  logic                load;
  logic                step_en;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_load, b_load;
  logic [WIDTH-1:0]    upper, lower;
  logic [2*WIDTH-1:0]  prod, prod_fix;
  logic [WIDTH-1:0]    quot_fix, rem_fix;

  assign op_in   = muldiv_op_e'(op);
  assign a_neg   = op_is_signed(op_in) & rs_data[WIDTH-1];
  assign b_neg   = op_is_signed(op_in) & rt_data[WIDTH-1];
  assign a_load  = a_neg ? -rs_data : rs_data;
  assign b_load  = b_neg ? -rt_data : rt_data;
  assign load    = (state_q == StIdle) & start;
  assign step_en = (state_q == StRun);

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (load),
    .step_i  (step_en),
    .is_div_i(op_is_div(op_q)),
    .a_i     (a_load),
    .b_i     (b_load),
    .upper_o (upper),
    .lower_o (lower)
  );

  // Divide-by-zero leaves |dividend| in the remainder, so restoring its sign
  // reproduces rs_data exactly; the quotient is forced to all ones.
  assign prod     = {upper, lower};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quot_fix = dz_q ? '1 : (neg_res_q ? -lower : lower);
  assign rem_fix  = neg_rem_q ? -upper : upper;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (hilo_we[1]) hi_d = rs_data;
        if (hilo_we[0]) lo_d = rs_data;
        if (start) begin
          state_d   = StRun;
          op_d      = op_in;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op_is_div(op_in) & (rt_data == '0);
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (cnt_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d     = 1'b1;
        div_zero_d = dz_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= OpMult;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign stall_EX = busy & (start | hilo_rd | (hilo_we != 2'b00));
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO results are queued when an
// operation is started and compared when done pulses.
module tb_muldiv_ctrl;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_rd;
  logic [1:0]  hilo_we;
  logic        stall_EX;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  muldiv_ctrl #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hilo_rd (hilo_rd),
    .hilo_we (hilo_we),
    .stall_EX(stall_EX),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic z);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.dz = z;
    return e;
  endfunction

  // Reference model using native 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] r, q, m;
    exp_t        e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = mk(32'h0, 32'h0, 1'b0);
    case (o)
      2'd0: begin
        r = 64'(sa * sb);
        e = mk(r[63:32], r[31:0], 1'b0);
      end
      2'd1: begin
        r = {32'h0, a} * {32'h0, b};
        e = mk(r[63:32], r[31:0], 1'b0);
      end
      default: begin
        if (b == 32'h0) begin
          e = mk(a, 32'hFFFF_FFFF, 1'b1);
        end else if (o == 2'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          q  = 64'(sq);
          m  = 64'(sr);
          e  = mk(m[31:0], q[31:0], 1'b0);
        end else begin
          e = mk(a % b, a / b, 1'b0);
        end
      end
    endcase
    return e;
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input bit push);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start   = 1'b0;
    hilo_we = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 100);
    check({tag, " latency"}, 64'(n), 64'd33);
    e = sb.pop_front();
    check({tag, " hi"}, {32'h0, hi}, {32'h0, e.hi});
    check({tag, " lo"}, {32'h0, lo}, {32'h0, e.lo});
    check({tag, " div_zero"}, {63'h0, div_zero}, {63'h0, e.dz});
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'd0;
    rs_data = '0;
    rt_data = '0;
    hilo_rd = 1'b0;
    hilo_we = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("reset hi", {32'h0, hi}, 64'h0);
    check("reset lo", {32'h0, lo}, 64'h0);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset div_zero", {63'h0, div_zero}, 64'h0);
    check("reset stall", {63'h0, stall_EX}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    start_op(2'd0, 32'hFFFF_FFFE, 32'h3, mk(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0), 1'b1);
    check("run busy", {63'h0, busy}, 64'h1);
    wait_done("mult -2*3");
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h1, 1'b0), 1'b1);
    wait_done("multu max");
    start_op(2'd2, 32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 1'b1);
    wait_done("div -7/2");
    start_op(2'd3, 32'h5, 32'h0, mk(32'h5, 32'hFFFF_FFFF, 1'b1), 1'b1);
    wait_done("divu 5/0");
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 1'b1);
    wait_done("div min/-1");
    start_op(2'd2, 32'hFFFF_FF9C, 32'h0, mk(32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1), 1'b1);
    wait_done("div -100/0");

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      start_op(2'(i), ra, rb, model(2'(i), ra, rb), 1'b1);
      wait_done("random op");
    end

    // MTHI then MTLO while idle.
    @(negedge clk);
    hilo_we = 2'b10;
    rs_data = 32'hA5A5_0001;
    @(negedge clk);
    hilo_we = 2'b01;
    rs_data = 32'h5A5A_0002;
    check("mthi hi", {32'h0, hi}, 64'hA5A5_0001);
    @(negedge clk);
    hilo_we = 2'b00;
    check("mtlo lo", {32'h0, lo}, 64'h5A5A_0002);
    check("mtlo hi kept", {32'h0, hi}, 64'hA5A5_0001);

    // MTHI/MTLO coinciding with start: written now, overwritten by FIX later.
    @(negedge clk);
    hilo_we = 2'b11;
    start_op(2'd0, 32'h5, 32'h7, mk(32'h0, 32'd35, 1'b0), 1'b1);
    check("we+start hi", {32'h0, hi}, 64'h5);
    check("we+start lo", {32'h0, lo}, 64'h5);
    wait_done("mult 5*7");

    // Stalled reads/starts during the operation, then accepted in the done cycle.
    start_op(2'd1, 32'h0001_0000, 32'h0003_0000, mk(32'h3, 32'h0, 1'b0), 1'b1);
    for (int n = 1; n <= 33; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n >= 4) begin
        hilo_rd = 1'b1;
        start   = 1'b1;
        op      = 2'd3;
        rs_data = 32'd100;
        rt_data = 32'd7;
      end
      #1;
      if (n >= 5 && n <= 32) begin
        check("busy stall", {63'h0, stall_EX}, 64'h1);
        check("busy hi held", {32'h0, hi}, 64'h0);
        check("busy lo held", {32'h0, lo}, 64'd35);
      end
    end
    begin
      exp_t e;
      e = sb.pop_front();
      check("done cycle done", {63'h0, done}, 64'h1);
      check("done cycle stall", {63'h0, stall_EX}, 64'h0);
      check("done cycle hi", {32'h0, hi}, {32'h0, e.hi});
      check("done cycle lo", {32'h0, lo}, {32'h0, e.lo});
    end
    sb.push_back(mk(32'd2, 32'd14, 1'b0));
    @(posedge clk);
    #1;
    start   = 1'b0;
    hilo_rd = 1'b0;
    wait_done("divu 100/7 back-to-back");

    // Reset mid-operation abandons it and clears HI/LO at once.
    start_op(2'd3, 32'd100, 32'd7, mk(32'h0, 32'h0, 1'b0), 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    rst   = 1'b0;
    #1;
    check("midrst hi", {32'h0, hi}, 64'h0);
    check("midrst lo", {32'h0, lo}, 64'h0);
    check("midrst busy", {63'h0, busy}, 64'h0);
    check("midrst stall", {63'h0, stall_EX}, 64'h0);
    check("midrst done", {63'h0, done}, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start_op(2'd3, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), 1'b1);
    wait_done("divu 100/7 after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request new MULT/MULTU/DIV/DIVU from EX.
REQ-005 SHALL have port op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
REQ-006 SHALL have port rs_data  input  WIDTH  multiplicand/dividend.
REQ-007 SHALL have port rt_data  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have port hilo_rd  input  1  EX is executing MFHI/MFLO this cycle.
REQ-009 SHALL have port hilo_we  input  2  bit1=MTHI, bit0=MTLO, data from rs_data.
REQ-010 SHALL have port stall_EX  output  1  hold fetch/execute this cycle.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse, HI/LO updated.
REQ-013 SHALL have port div_zero  output  1  one-cycle pulse with done when divisor was 0.
REQ-014 SHALL have port hi  output  WIDTH  HI register, to writeback aluhi.
REQ-015 SHALL have port lo  output  WIDTH  LO register, to writeback lo.

Function
REQ-016 SHALL implement states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-017 SHALL, in IDLE with start=1 at edge k, latch op, operand signs and absolute values (signed ops) or raw values (unsigned ops), clear 6-bit counter, enter RUN.
REQ-018 SHALL, in RUN, perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles, then enter FIX.
REQ-019 SHALL, in FIX, apply sign correction, write hi/lo, pulse done, return to IDLE; done visible after edge k+33 (34-cycle start-to-done latency at WIDTH=32), independent of operand values.
REQ-020 SHALL produce multiply result {hi,lo} = full 2*WIDTH product, negated when operand signs differ (signed only).
REQ-021 SHALL produce divide lo=quotient, hi=remainder; signed quotient negated when signs differ, remainder takes dividend sign.
REQ-022 SHALL, for divisor 0, skip sign correction and produce hi=rs_data, lo=all ones, div_zero=1 with done.
REQ-023 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0, no div_zero.
REQ-024 SHALL drive stall_EX = busy & (start | hilo_rd | hilo_we!=0), combinationally; stalled requests are ignored and retried by EX.
REQ-025 SHALL, in the done cycle (state IDLE), accept start and serve hilo_rd with the new hi/lo values, no stall.
REQ-026 SHALL, in IDLE, write hi and/or lo from rs_data on hilo_we at the clock edge; if start coincides, perform both, the later FIX result overwriting.
REQ-027 SHALL keep hi/lo unchanged during RUN; hi/lo change only in FIX or on hilo_we.

Reset
REQ-028 SHALL, on rst low, immediately force state=IDLE, hi=0, lo=0, counter=0, busy=0, done=0, div_zero=0, stall_EX=0.
REQ-029 SHALL abandon any in-flight operation on reset without updating hi/lo; first start after release begins a fresh 34-cycle operation.

Structure
REQ-030 SHALL place op encodings, state encoding and WIDTH default in shared package muldiv_pkg.
REQ-031 SHALL split the per-cycle step datapath (accumulator, shift, add/subtract) into sub-module muldiv_step; muldiv_ctrl holds FSM, counter, sign logic, HI/LO.

Verification
REQ-032 SHALL cover MULT rs=0xFFFFFFFE(-2), rt=3 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 SHALL cover MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL cover DIV rs=-7, rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF, div_zero=1.
REQ-035 SHALL cover hilo_rd and second start at cycles 5..33 of an operation -> stall_EX=1 each cycle, hi/lo unchanged; same in done cycle -> stall_EX=0, new values read.
REQ-036 SHALL cover rst low at cycle 20 of DIVU 100/7 -> hi=lo=0, busy=0 immediately; restart completes with lo=14, hi=2.
